// File: rtl/reg_bank_mp.sv
// Register bank with one write port and two registered read ports, plus a sequential clear engine.
// Optional same-cycle write-to-read forwarding is enabled by defining RB_BYPASS_EN.
module reg_bank_mp #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 35,
    parameter int ADDR_W   = 6,
    parameter int R0_ZERO  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_a_addr,
    input  logic [ADDR_W-1:0] rd_b_addr,
    input  logic              clr_req,
    output logic [DATA_W-1:0] rd_a_data,
    output logic [DATA_W-1:0] rd_b_data,
    output logic              busy,
    output logic              wr_err
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   NUM_REGS_C = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_IDX_C = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] CNT_ONE_C  = ADDR_W'(1);
`ifdef RB_BYPASS_EN
    localparam logic BYPASS_C = 1'b1;
`else
    localparam logic BYPASS_C = 1'b0;
`endif

    function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < NUM_REGS_C);
    endfunction

    function automatic logic addr_forced_zero(input logic [ADDR_W-1:0] addr);
        return (R0_ZERO != 0) && (addr == {ADDR_W{1'b0}});
    endfunction

    function automatic logic [DATA_W-1:0] read_sel(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] reg_val,
        input logic              fwd,
        input logic [DATA_W-1:0] fwd_val
    );
        logic [DATA_W-1:0] val;
        if (!addr_legal(addr) || addr_forced_zero(addr)) begin
            val = {DATA_W{1'b0}};
        end else if (fwd) begin
            val = fwd_val;
        end else begin
            val = reg_val;
        end
        return val;
    endfunction

    state_t            state_r;
    state_t            state_n_s;
    logic [ADDR_W-1:0] clr_cnt_r;
    logic [ADDR_W-1:0] clr_cnt_n_s;
    logic [DATA_W-1:0] regs_r [0:NUM_REGS-1];
    logic [DATA_W-1:0] rd_a_raw_s;
    logic [DATA_W-1:0] rd_b_raw_s;
    logic [DATA_W-1:0] rd_a_n_s;
    logic [DATA_W-1:0] rd_b_n_s;
    logic              wr_commit_s;
    logic              wr_err_n_s;
    logic [DATA_W-1:0] rd_a_data_r;
    logic [DATA_W-1:0] rd_b_data_r;
    logic              busy_r;
    logic              wr_err_r;

    // Out-of-range addresses index garbage here; read_sel masks them to zero.
    assign rd_a_raw_s = regs_r[rd_a_addr];
    assign rd_b_raw_s = regs_r[rd_b_addr];

    // Next-state, write qualification and next read values.
    always_comb begin
        state_n_s   = state_r;
        clr_cnt_n_s = clr_cnt_r;
        wr_commit_s = 1'b0;
        wr_err_n_s  = 1'b0;
        rd_a_n_s    = {DATA_W{1'b0}};
        rd_b_n_s    = {DATA_W{1'b0}};
        case (state_r)
            ST_CLEAR: begin
                if (clr_cnt_r == LAST_IDX_C) begin
                    state_n_s   = ST_IDLE;
                    clr_cnt_n_s = {ADDR_W{1'b0}};
                end else begin
                    clr_cnt_n_s = clr_cnt_r + CNT_ONE_C;
                end
            end
            ST_IDLE: begin
                wr_commit_s = wr_en && addr_legal(wr_addr) && !addr_forced_zero(wr_addr);
                wr_err_n_s  = wr_en && !addr_legal(wr_addr);
                // Reads are suppressed on the entry edge so outputs are 0 whenever busy is high.
                if (clr_req) begin
                    state_n_s   = ST_CLEAR;
                    clr_cnt_n_s = {ADDR_W{1'b0}};
                end else begin
                    rd_a_n_s = read_sel(rd_a_addr, rd_a_raw_s,
                                        BYPASS_C && wr_commit_s && (wr_addr == rd_a_addr), wr_data);
                    rd_b_n_s = read_sel(rd_b_addr, rd_b_raw_s,
                                        BYPASS_C && wr_commit_s && (wr_addr == rd_b_addr), wr_data);
                end
            end
            default: begin
                state_n_s   = ST_CLEAR;
                clr_cnt_n_s = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_CLEAR;
            clr_cnt_r   <= {ADDR_W{1'b0}};
            busy_r      <= 1'b1;
            rd_a_data_r <= {DATA_W{1'b0}};
            rd_b_data_r <= {DATA_W{1'b0}};
            wr_err_r    <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            clr_cnt_r   <= clr_cnt_n_s;
            busy_r      <= (state_n_s == ST_CLEAR);
            rd_a_data_r <= rd_a_n_s;
            rd_b_data_r <= rd_b_n_s;
            wr_err_r    <= wr_err_n_s;
        end
    end

    // Storage array: intentionally unreset, the clear engine zeroes it after reset release.
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            regs_r[clr_cnt_r] <= {DATA_W{1'b0}};
        end else if (wr_commit_s) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    assign rd_a_data = rd_a_data_r;
    assign rd_b_data = rd_b_data_r;
    assign busy      = busy_r;
    assign wr_err    = wr_err_r;

endmodule
